// File: rtl/rd_stream_ctrl.sv
// rd_stream_ctrl: runs one block read through the address generator and
// streams the returned memory words out over a valid/ready interface.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             one-cycle block request (ignored unless idle)
//   gen_rst, gen_ce   clear / count enable to the address generator
//   mem_dout          memory data, valid MEM_LAT cycles after gen_ce
//   out_data/valid    stream output (FIFO head), out_ready from consumer
//   busy, done        block in progress / last-transfer pulse
module rd_stream_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TOTAL      = 40,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              gen_rst,
  output logic              gen_ce,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(TOTAL + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = CW + LW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_issued;
  logic [MEM_LAT-1:0] r_infl;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [LW-1:0] w_nfl;
  logic [OW-1:0] w_occ;
  logic          w_last;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_nfl = '0;
    for (int i = 0; i < MEM_LAT; i++)
      w_nfl = w_nfl + LW'(r_infl[i]);
  end

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_infl[MEM_LAT-1];

  // Credit: buffered + in flight, less what leaves this cycle, must
  // leave room for one more word before another read is issued.
  assign w_occ = OW'(r_count) + OW'(w_nfl) - OW'(w_pop);

  assign gen_ce = (r_state == FETCH)
               && (r_issued < IW'(TOTAL))
               && (w_occ < OW'(FIFO_DEPTH));

  assign w_last    = gen_ce && (r_issued == IW'(TOTAL - 1));
  assign gen_rst   = rst | (r_state == CLEAR);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rptr];
  assign done      = (r_state == DRAIN)
                  && (w_nfl == '0)
                  && (r_count == CW'(1))
                  && w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_issued <= '0;
      r_infl   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--)
        r_infl[i] <= r_infl[i-1];
      r_infl[0] <= gen_ce;

      if (w_push) begin
        r_mem[r_wptr] <= mem_dout;
        r_wptr        <= nxt(r_wptr);
      end
      if (w_pop)
        r_rptr <= nxt(r_rptr);

      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + 1'b1;
        (!w_push && w_pop): r_count <= r_count - 1'b1;
        default:            r_count <= r_count;
      endcase

      unique case (r_state)
        IDLE:
          if (start)
            r_state <= CLEAR;
        CLEAR: begin
          r_issued <= '0;
          r_state  <= FETCH;
        end
        FETCH:
          if (gen_ce) begin
            r_issued <= r_issued + 1'b1;
            if (w_last)
              r_state <= DRAIN;
          end
        DRAIN:
          if (done)
            r_state <= IDLE;
        default:
          r_state <= IDLE;
      endcase
    end
  end

endmodule
